// File: rtl/lcd_panel_responder_if.sv
// HD44780-style parallel bus between the LCD host controller (master) and the
// panel responder (slave).
interface lcd_panel_responder_if;
  logic       e;
  logic       rs;
  logic       rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       data_oe;

  modport master (
    output e, rs, rw, lcd_data_in,
    input  lcd_data_out, data_oe
  );

  modport slave (
    input  e, rs, rw, lcd_data_in,
    output lcd_data_out, data_oe
  );
endinterface

// File: rtl/lcd_panel_responder.sv
// Character-LCD module side of the HD44780 bus: captures transactions on the
// falling edge of e, decodes instructions, keeps DDRAM/AC/flags, models busy time.
module lcd_panel_responder #(
  parameter int unsigned CLK_FREQ       = 30,
  parameter int unsigned DDRAM_DEPTH    = 80,
  parameter int unsigned POWERUP_CYCLES = 10000,
  parameter int unsigned CMD_CYCLES     = 1110,
  parameter int unsigned CLR_CYCLES     = 4500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lcd_panel_responder_if.slave  bus,
  output logic                  busy_flag,
  output logic [6:0]            addr_cnt,
  output logic                  display_on,
  output logic                  cursor_on,
  output logic                  blink_on,
  output logic                  two_line,
  output logic                  font_5x10,
  output logic                  incr_mode,
  output logic                  shift_mode,
  output logic [6:0]            shift_ofs,
  output logic                  protocol_err,
  input  logic [6:0]            dbg_addr,
  output logic [7:0]            dbg_data
);

  localparam logic [6:0]  LAST   = 7'(DDRAM_DEPTH - 1);
  localparam logic [15:0] PU_LD  = 16'(POWERUP_CYCLES);
  localparam logic [15:0] CMD_LD = 16'(CMD_CYCLES);
  localparam logic [15:0] CLR_LD = 16'(CLR_CYCLES);
  localparam logic [7:0]  BLANK  = 8'h20;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (CLK_FREQ == 0 || DDRAM_DEPTH == 0 || DDRAM_DEPTH > 128) begin : g_bad_param
    $error("lcd_panel_responder: CLK_FREQ must be nonzero and DDRAM_DEPTH in 1..128");
  end

  logic [7:0]  mem [DDRAM_DEPTH];
  logic [0:0]  state;
  logic [6:0]  fill_idx;
  logic [15:0] busy_cnt, busy_cnt_next;

  logic       e_q, rs_q, rw_q;
  logic [7:0] data_q;
  logic       cgram_mode;

  logic       fall, exec, violation, do_op;
  logic       load, mem_we, start_clear;
  logic [15:0] load_val;
  logic [6:0] ac_n, ofs_n;
  logic       disp_n, cur_n, blink_n, two_n, font_n, incr_n, shift_n, cg_n;

  function automatic logic [6:0] step(input logic [6:0] v, input logic up);
    if (up) return (v == LAST) ? 7'd0 : v + 7'd1;
    else    return (v == 7'd0) ? LAST : v - 7'd1;
  endfunction

  // rs=0 reads have no side effects, so they never execute nor count as violations
  assign fall      = !bus.e && e_q;
  assign exec      = fall && !(rw_q && !rs_q);
  assign violation = exec && busy_flag;
  assign do_op     = exec && !busy_flag;

  always_comb begin
    ac_n        = addr_cnt;
    ofs_n       = shift_ofs;
    disp_n      = display_on;
    cur_n       = cursor_on;
    blink_n     = blink_on;
    two_n       = two_line;
    font_n      = font_5x10;
    incr_n      = incr_mode;
    shift_n     = shift_mode;
    cg_n        = cgram_mode;
    load        = 1'b0;
    load_val    = CMD_LD;
    mem_we      = 1'b0;
    start_clear = 1'b0;
    if (do_op) begin
      if (rs_q) begin
        load = 1'b1;
        if (rw_q) begin
          ac_n = step(addr_cnt, incr_mode);
        end else if (!cgram_mode) begin
          mem_we = 1'b1;
          ac_n   = step(addr_cnt, incr_mode);
          if (shift_mode) ofs_n = step(shift_ofs, incr_mode);
        end
      end else begin
        casez (data_q)
          8'b1???????: begin
            cg_n = 1'b0;
            ac_n = (data_q[6:0] <= LAST) ? data_q[6:0] : 7'd0;
            load = 1'b1;
          end
          8'b01??????: begin
            cg_n = 1'b1;
            load = 1'b1;
          end
          8'b001?????: begin
            two_n  = data_q[3];
            font_n = data_q[2];
            load   = 1'b1;
          end
          8'b0001????: begin
            if (data_q[3]) ofs_n = step(shift_ofs, data_q[2]);
            else           ac_n  = step(addr_cnt, data_q[2]);
            load = 1'b1;
          end
          8'b00001???: begin
            disp_n  = data_q[2];
            cur_n   = data_q[1];
            blink_n = data_q[0];
            load    = 1'b1;
          end
          8'b000001??: begin
            incr_n  = data_q[1];
            shift_n = data_q[0];
            load    = 1'b1;
          end
          8'b0000001?: begin
            ac_n     = 7'd0;
            ofs_n    = 7'd0;
            load     = 1'b1;
            load_val = CLR_LD;
          end
          8'b00000001: begin
            ac_n        = 7'd0;
            ofs_n       = 7'd0;
            incr_n      = 1'b1;
            start_clear = 1'b1;
            load        = 1'b1;
            load_val    = CLR_LD;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    if (load)                busy_cnt_next = load_val;
    else if (busy_cnt != '0) busy_cnt_next = busy_cnt - 16'd1;
    else                     busy_cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_FILL;
      fill_idx         <= '0;
      busy_cnt         <= PU_LD;
      busy_flag        <= 1'b1;
      e_q              <= 1'b0;
      rs_q             <= 1'b0;
      rw_q             <= 1'b0;
      data_q           <= '0;
      cgram_mode       <= 1'b0;
      addr_cnt         <= '0;
      shift_ofs        <= '0;
      display_on       <= 1'b0;
      cursor_on        <= 1'b0;
      blink_on         <= 1'b0;
      two_line         <= 1'b0;
      font_5x10        <= 1'b0;
      incr_mode        <= 1'b1;
      shift_mode       <= 1'b0;
      protocol_err     <= 1'b0;
      bus.lcd_data_out <= '0;
      bus.data_oe      <= 1'b0;
    end else begin
      busy_cnt  <= busy_cnt_next;
      busy_flag <= (busy_cnt_next != '0);
      e_q       <= bus.e;
      if (bus.e) begin
        rs_q   <= bus.rs;
        rw_q   <= bus.rw;
        data_q <= bus.lcd_data_in;
      end

      // Blank-fill sequencer; clear always runs under a busy window far longer than the fill
      if (start_clear) begin
        state    <= ST_FILL;
        fill_idx <= '0;
      end else if (state == ST_FILL) begin
        if (fill_idx == LAST) state <= ST_RUN;
        else                  fill_idx <= fill_idx + 7'd1;
      end

      cgram_mode <= cg_n;
      addr_cnt   <= ac_n;
      shift_ofs  <= ofs_n;
      display_on <= disp_n;
      cursor_on  <= cur_n;
      blink_on   <= blink_n;
      two_line   <= two_n;
      font_5x10  <= font_n;
      incr_mode  <= incr_n;
      shift_mode <= shift_n;
      if (violation) protocol_err <= 1'b1;

      bus.data_oe <= bus.e && bus.rw;
      if (bus.e && bus.rw) begin
        if (bus.rs) bus.lcd_data_out <= cgram_mode ? 8'h00 : mem[addr_cnt];
        else        bus.lcd_data_out <= {busy_flag, addr_cnt};
      end else begin
        bus.lcd_data_out <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_FILL) mem[fill_idx] <= BLANK;
    else if (mem_we)      mem[addr_cnt] <= data_q;
  end

  assign dbg_data = (dbg_addr <= LAST) ? mem[dbg_addr] : 8'h00;

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Directed bench for lcd_panel_responder: power-up busy, host init sequence,
// DDRAM writes/reads with AC wrap, busy violations and mid-clear reset.
module tb_lcd_panel_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       display_on, cursor_on, blink_on;
  logic       two_line, font_5x10, incr_mode, shift_mode;
  logic [6:0] shift_ofs;
  logic       protocol_err;
  logic [6:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;

  lcd_panel_responder_if bus ();

  lcd_panel_responder #(
    .CLK_FREQ(30), .DDRAM_DEPTH(80), .POWERUP_CYCLES(10000),
    .CMD_CYCLES(1110), .CLR_CYCLES(4500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy_flag(busy_flag), .addr_cnt(addr_cnt),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .font_5x10(font_5x10), .incr_mode(incr_mode),
    .shift_mode(shift_mode), .shift_ofs(shift_ofs), .protocol_err(protocol_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int hold);
    bus.rs = rs; bus.rw = rw; bus.lcd_data_in = d; bus.e = 1'b1;
    repeat (hold) @(negedge clk);
    bus.e = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic rs, input int hold, output logic [7:0] d, output logic oe);
    bus.rs = rs; bus.rw = 1'b1; bus.e = 1'b1;
    repeat (hold) @(negedge clk);
    d  = bus.lcd_data_out;
    oe = bus.data_oe;
    bus.e = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_flag && n < 20000) begin
      n++;
      @(negedge clk);
    end
    if (busy_flag) chk(tag, 32'(busy_flag), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy_flag && n < 20000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic peek(input logic [6:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1 d = dbg_data;
  endtask

  initial begin
    int n;
    int unsigned c0;
    logic [7:0] d;
    logic oe;
    bus.e = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0; bus.lcd_data_in = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_flag), 32'd1);
    chk("rst_incr", 32'(incr_mode), 32'd1);
    chk("rst_ac", 32'(addr_cnt), 32'd0);
    chk("rst_disp", 32'({display_on, cursor_on, blink_on, two_line, font_5x10, shift_mode}), 32'd0);
    chk("rst_err_oe", 32'({protocol_err, bus.data_oe}), 32'd0);

    rst_n = 1'b1;
    busy_len(n);
    chk("powerup_len", 32'(n), 32'd10000);
    repeat (3) @(negedge clk);

    xfer(1'b0, 1'b0, 8'h38, 300); wait_idle("to_38");
    xfer(1'b0, 1'b0, 8'h0F, 2);   wait_idle("to_0f");
    xfer(1'b0, 1'b0, 8'h01, 2);   wait_idle("to_01");
    xfer(1'b0, 1'b0, 8'h06, 2);   wait_idle("to_06");
    chk("init_func", 32'({two_line, font_5x10}), 32'b10);
    chk("init_disp", 32'({display_on, cursor_on, blink_on}), 32'b111);
    chk("init_entry", 32'({incr_mode, shift_mode}), 32'b10);
    chk("init_err", 32'(protocol_err), 32'd0);
    peek(7'd0, d);  chk("blank0", 32'(d), 32'h20);
    peek(7'd40, d); chk("blank40", 32'(d), 32'h20);
    peek(7'd79, d); chk("blank79", 32'(d), 32'h20);
    peek(7'd90, d); chk("dbg_oob", 32'(d), 32'h00);

    xfer(1'b1, 1'b0, 8'h41, 2);
    busy_len(n);
    chk("wr_busy_len", 32'(n), 32'd1110);
    peek(7'd0, d); chk("wr41", 32'(d), 32'h41);
    chk("wr41_ac", 32'(addr_cnt), 32'd1);
    repeat (3) @(negedge clk);

    xfer(1'b0, 1'b0, 8'hCF, 2); wait_idle("to_cf");
    chk("setaddr79", 32'(addr_cnt), 32'd79);
    xfer(1'b1, 1'b0, 8'h5A, 2); wait_idle("to_5a");
    peek(7'd79, d); chk("wr5a", 32'(d), 32'h5A);
    chk("ac_wrap_up", 32'(addr_cnt), 32'd0);
    xfer(1'b0, 1'b0, 8'h04, 2); wait_idle("to_04");
    chk("decr_mode", 32'(incr_mode), 32'd0);
    xfer(1'b1, 1'b0, 8'h33, 2); wait_idle("to_33");
    peek(7'd0, d); chk("wr33", 32'(d), 32'h33);
    chk("ac_wrap_dn", 32'(addr_cnt), 32'd79);

    xfer(1'b0, 1'b0, 8'hD0, 2); wait_idle("to_d0");
    chk("setaddr_oob", 32'(addr_cnt), 32'd0);
    xfer(1'b0, 1'b0, 8'h14, 2); wait_idle("to_14");
    chk("cur_right", 32'(addr_cnt), 32'd1);
    xfer(1'b0, 1'b0, 8'h18, 2); wait_idle("to_18");
    chk("disp_left", 32'(shift_ofs), 32'd79);
    xfer(1'b0, 1'b0, 8'h06, 2); wait_idle("to_06b");

    xfer(1'b0, 1'b0, 8'h01, 2);
    rd(1'b0, 3, d, oe);
    chk("bf_read", 32'(d), 32'h80);
    chk("bf_oe", 32'(oe), 32'd1);
    chk("oe_drop", 32'(bus.data_oe), 32'd0);
    chk("bf_no_err", 32'(protocol_err), 32'd0);
    chk("clr_ofs", 32'(shift_ofs), 32'd0);
    wait_idle("to_clr");
    peek(7'd79, d); chk("clr79", 32'(d), 32'h20);

    xfer(1'b1, 1'b0, 8'h4B, 2); wait_idle("to_4b");
    xfer(1'b0, 1'b0, 8'h80, 2); wait_idle("to_80");
    rd(1'b1, 2, d, oe);
    chk("data_read", 32'(d), 32'h4B);
    chk("data_read_ac", 32'(addr_cnt), 32'd1);
    xfer(1'b0, 1'b0, 8'h08, 2);
    chk("viol_err", 32'(protocol_err), 32'd1);
    chk("viol_ignored", 32'({display_on, cursor_on, blink_on}), 32'b111);
    wait_idle("to_viol");

    xfer(1'b0, 1'b0, 8'h01, 2);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_flag), 32'd1);
    chk("mid_rst_flags", 32'({display_on, two_line, protocol_err, incr_mode}), 32'b0001);
    chk("mid_rst_ac", 32'(addr_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    repeat (5) @(negedge clk);
    xfer(1'b0, 1'b0, 8'h0C, 2);
    chk("pu_viol_err", 32'(protocol_err), 32'd1);
    chk("pu_viol_flags", 32'(display_on), 32'd0);
    while (cyc < c0 + 9999) @(negedge clk);
    chk("pu2_last_busy", 32'(busy_flag), 32'd1);
    @(negedge clk);
    chk("pu2_done", 32'(busy_flag), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_panel_responder.md
Name: lcd_panel_responder

Overview:
- Cycle-accurate model of the character-LCD module side of the HD44780-style parallel bus: e, rs, rw and 8-bit data.
- Our LCD host controller drives this bus; this block is the device it drives.
- Captures bus transactions on the falling edge of e and decodes instructions.
- Maintains DDRAM, the address counter and the display flags, and enforces busy timing.
- Answers busy-flag and data reads.
- Used as a bench responder and as a formal environment for the host controller.

Parameters:
- CLK_FREQ, 30: clock cycles per microsecond, for documentation only.
- DDRAM_DEPTH, 80: number of DDRAM bytes; linear address space 0..DDRAM_DEPTH-1.
- POWERUP_CYCLES, 10000: busy duration after reset deasserts.
- CMD_CYCLES, 1110: busy duration for ordinary instructions and data reads/writes.
- CLR_CYCLES, 4500: busy duration for clear display and return home.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- e  in  1  enable strobe from host
- rs  in  1  register select: 0 = instruction, 1 = data
- rw  in  1  0 = write, 1 = read
- lcd_data_in  in  8  bus data from host
- lcd_data_out  out  8  read data to host
- data_oe  out  1  responder drives the bus
- busy_flag  out  1  instruction in progress
- addr_cnt  out  7  address counter (AC)
- display_on / cursor_on / blink_on  out  1 each  display-control flags
- two_line / font_5x10 / incr_mode / shift_mode  out  1 each  function-set and entry-mode flags
- shift_ofs  out  7  display shift offset
- protocol_err  out  1  sticky flag: access attempted while busy
- dbg_addr  in  7  DDRAM debug read address
- dbg_data  out  8  DDRAM[dbg_addr], combinational; 0x00 if dbg_addr >= DDRAM_DEPTH

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, except incr_mode=1 and busy_flag=1.
  - AC=0, shift_ofs=0, CGRAM mode off.
  - DDRAM filled with 0x20. This may complete during the power-up busy period, but must be finished before busy_flag falls.
  - Busy counter loaded with POWERUP_CYCLES.
- Busy counter:
  - Decrements each cycle while nonzero.
  - busy_flag = (counter != 0), registered.
- Capture:
  - rs, rw and lcd_data_in are registered on every cycle in which e=1.
  - A transaction is executed on the first cycle with e=0 after a cycle with e=1 (falling edge), using the captured values.
- Reads:
  - While e=1 and rw=1, data_oe=1 (registered, one cycle after e rises). It drops the cycle after e falls.
  - rs=0 read: lcd_data_out = {busy_flag, AC}. Always allowed, including while busy; no side effects.
  - rs=1 read:
    - DDRAM mode: lcd_data_out = DDRAM[AC]. CGRAM mode: lcd_data_out = 0x00.
    - On the falling edge, AC steps per incr_mode and busy is loaded with CMD_CYCLES.
- Writes (rw=0), decoded by the highest set bit of the data byte:
  - 0x01, clear display: DDRAM all 0x20, AC=0, incr_mode=1, shift_ofs=0; busy=CLR_CYCLES.
  - 0x02/0x03, return home: AC=0, shift_ofs=0; busy=CLR_CYCLES.
  - 0000_01IS, entry mode: incr_mode=I, shift_mode=S.
  - 0000_1DCB, display control: display_on=D, cursor_on=C, blink_on=B.
  - 0001_SR--, shift:
    - S=0 moves the cursor: AC ±1.
    - S=1 shifts the display: shift_ofs ±1 modulo DDRAM_DEPTH.
    - R=1 is the + direction.
  - 001D_NF--, function set: two_line=N, font_5x10=F. D is ignored (8-bit bus only).
  - 01AA_AAAA, set CGRAM address: enter CGRAM mode. Subsequent data writes are discarded; AC is unchanged.
  - 1AAA_AAAA, set DDRAM address: leave CGRAM mode. AC=A if A<DDRAM_DEPTH, else AC=0.
  - 0x00: no operation; busy is not set.
  - Data write (rs=1), DDRAM mode: DDRAM[AC]=data, then AC steps.
  - Every instruction except clear, return home and 0x00 loads busy with CMD_CYCLES. Data writes load busy with CMD_CYCLES.
- AC stepping:
  - incr_mode=1: AC+1, wrapping DDRAM_DEPTH-1 -> 0.
  - incr_mode=0: AC-1, wrapping 0 -> DDRAM_DEPTH-1.
  - If shift_mode=1, a data write also shifts shift_ofs in the same direction.
- Busy violation:
  - Any transaction other than an rs=0 read whose falling edge occurs while busy_flag=1 is ignored.
  - It sets protocol_err=1; only reset clears protocol_err.
  - The falling edge of the last busy cycle counts as busy.
- Simultaneous events: a falling edge in the same cycle the counter reaches 0 is treated as busy. Reset overrides everything, including mid-busy.
- e held high indefinitely: the transaction executes only when e falls.

Test Plan:
- Release reset, e=0 -> busy_flag=1 for exactly 10000 cycles. Any write inside the window sets protocol_err=1 and leaves flags unchanged.
- After power-up, host-style init: 0x38 (e high 300 cycles), 0x0F, 0x01, 0x06, with the host's gap timing -> two_line=1, font_5x10=0, display_on=cursor_on=blink_on=1, incr_mode=1, protocol_err=0. dbg_data=0x20 at addresses 0, 40 and 79.
- Data write rs=1, 0x41 -> dbg_data at address 0 = 0x41, AC=1, busy_flag=1 for 1110 cycles.
- Instruction 0xCF (AC=79), then data write 0x5A -> dbg_data at address 79 = 0x5A, AC wraps to 0. Then 0x04 (decrement mode) plus a write -> AC=79.
- rs=0, rw=1 read during a clear -> data_oe=1, lcd_data_out=0x80|AC, no protocol_err. After busy ends, an rs=1 read returns DDRAM[AC] and AC steps.
- Assert rst_n=0 mid-clear -> outputs return to reset values immediately; busy restarts with POWERUP_CYCLES.
